// File: rtl/btn_debounce_pulse.sv
// -----------------------------------------------------------------------------
// btn_debounce_pulse
//
// Conditions a raw mechanical push-button for the downstream consumer logic.
// The asynchronous pin is brought into the clock domain through a two-flop
// synchroniser. A four-state FSM then accepts a change only after the
// synchronised level has held steady for DEBOUNCE_CYCLES consecutive cycles.
// It produces a clean level and single-cycle press and release strobes.
// All outputs are registered.
//
// Optional feature (compile-time macro AUTO_REPEAT_EN):
//   When the macro is defined, a held button re-fires o_btn_pulse.
//   The first repeat comes REPEAT_DELAY cycles after the press pulse.
//   Later repeats come every REPEAT_PERIOD cycles.
//   When the macro is undefined, no repeat logic exists and each accepted
//   press gives exactly one pulse.
//
// Parameters:
//   CNT_W           width of the debounce counter
//   DEBOUNCE_CYCLES stable cycles needed to accept a change (1 .. 2^CNT_W-1)
//   REPEAT_DELAY    hold time before the first auto-repeat pulse
//   REPEAT_PERIOD   spacing of subsequent auto-repeat pulses
//
// Ports:
//   i_clk          system clock, rising-edge active
//   i_rst_n        asynchronous active-low reset
//   i_btn          raw, bouncy button pin (1 = pressed)
//   o_btn_level    debounced button level
//   o_btn_pulse    one-cycle strobe per accepted press (and per auto-repeat)
//   o_btn_release  one-cycle strobe per accepted release
// -----------------------------------------------------------------------------
module btn_debounce_pulse #(
  parameter int CNT_W           = 20,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_btn_level,
  output logic o_btn_pulse,
  output logic o_btn_release
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    ARM_RELEASE = 2'd3
  } state_t;

  // Terminal count: reaching it while still stable completes the debounce.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Sanity check on the configuration.
  // An illegal setting elaborates this marker block, which then shows up in
  // the hierarchy as g_bad_config.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_config
  end

  logic   r_s1;
  logic   r_btn_s;
  state_t r_state;
  logic   [CNT_W-1:0] r_cnt;

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] r_rpt;
  logic             r_rpt_first;
  logic [RPT_W-1:0] w_rpt_target;

  // The first repeat after entering PRESSED waits the long delay.
  // Every repeat after that uses the shorter period.
  assign w_rpt_target = r_rpt_first ? RPT_DELAY_LAST : RPT_PERIOD_LAST;
`endif

  // Two-flop synchroniser. Nothing downstream ever looks at i_btn directly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1    <= 1'b0;
      r_btn_s <= 1'b0;
    end else begin
      r_s1    <= i_btn;
      r_btn_s <= r_s1;
    end
  end

  // Debounce FSM.
  // The counter is cleared on every state change and only advances while the
  // synchronised input disagrees with the accepted level.
  // The pulse strobes default low, so each one lasts exactly one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      o_btn_level   <= 1'b0;
      o_btn_pulse   <= 1'b0;
      o_btn_release <= 1'b0;
`ifdef AUTO_REPEAT_EN
      r_rpt         <= '0;
      r_rpt_first   <= 1'b1;
`endif
    end else begin
      o_btn_pulse   <= 1'b0;
      o_btn_release <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (r_btn_s) begin
            r_state <= ARM_PRESS;
          end
        end

        ARM_PRESS: begin
          if (!r_btn_s) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state     <= PRESSED;
            r_cnt       <= '0;
            o_btn_level <= 1'b1;
            o_btn_pulse <= 1'b1;
`ifdef AUTO_REPEAT_EN
            r_rpt       <= '0;
            r_rpt_first <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        PRESSED: begin
          r_cnt <= '0;
          if (!r_btn_s) begin
            r_state <= ARM_RELEASE;
`ifdef AUTO_REPEAT_EN
            r_rpt       <= '0;
            r_rpt_first <= 1'b1;
`endif
          end
`ifdef AUTO_REPEAT_EN
          else if (r_rpt == w_rpt_target) begin
            r_rpt       <= '0;
            r_rpt_first <= 1'b0;
            o_btn_pulse <= 1'b1;
          end else begin
            r_rpt <= r_rpt + RPT_W'(1);
          end
`endif
        end

        ARM_RELEASE: begin
          if (r_btn_s) begin
            // A bounce back high returns to PRESSED without a new press pulse.
            // Repeat timing restarts from this re-entry.
            r_state <= PRESSED;
            r_cnt   <= '0;
`ifdef AUTO_REPEAT_EN
            r_rpt       <= '0;
            r_rpt_first <= 1'b1;
`endif
          end else if (r_cnt == CNT_LAST) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            o_btn_level   <= 1'b0;
            o_btn_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce_pulse
//
// Self-checking bench for btn_debounce_pulse, with DEBOUNCE_CYCLES=4, CNT_W=4,
// REPEAT_DELAY=10 and REPEAT_PERIOD=5.
//
// The reference model does not follow the DUT's state machine. It describes
// the behaviour directly:
//   - The FSM sees the pin value sampled two edges earlier.
//   - A new level is accepted once the seen value has disagreed with the
//     current level for DEBOUNCE_CYCLES+1 consecutive edges.
//   - Repeats fall at fixed edge distances from the last entry into the held
//     state.
// Directed sequences pin the model with literal expectations. A long random
// run, with occasional resets, is then compared every cycle.
// -----------------------------------------------------------------------------
module tb_btn_debounce_pulse;

  localparam int CNT_W   = 4;
  localparam int DEB     = 4;
  localparam int RDELAY  = 10;
  localparam int RPERIOD = 5;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  logic btn  = 1'b0;
  logic btnLevel;
  logic btnPulse;
  logic btnRelease;

  int numChecks    = 0;
  int numFails     = 0;
  int pulseCount   = 0;
  int releaseCount = 0;

  btn_debounce_pulse #(
    .CNT_W          (CNT_W),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RDELAY),
    .REPEAT_PERIOD  (RPERIOD)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_btn        (btn),
    .o_btn_level  (btnLevel),
    .o_btn_pulse  (btnPulse),
    .o_btn_release(btnRelease)
  );

  always #5 clk = ~clk;

  // One comparison: counts it, and prints a FAIL line if it does not hold.
  task automatic checkOutput(input string name, input logic actual, input logic expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Integer-valued variant of the comparison, used for event counts.
  task automatic checkCount(input string name, input int actual, input int expected);
    numChecks++;
    if (actual != expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Holds the pin at one value for a number of cycles.
  // Call it on a falling edge; it returns on a falling edge.
  task automatic applyStimulus(input logic value, input int cycles);
    btn = value;
    repeat (cycles) @(negedge clk);
  endtask

  // Waits for n rising edges, then settles just after the last one.
  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Reference model.
  //   mHist0/mHist1 : pin samples from one and two edges back.
  //   mRun          : consecutive edges the seen value has disagreed with the level.
  //   mHeld         : edges spent continuously held since the last entry to "held".
  logic mHist0, mHist1;
  int   mRun, mHeld;
  logic expLevel, expPulse, expRelease;

  always @(posedge clk or negedge rstN) begin : refModel
    logic seen;
    logic lvl;
    logic pul;
    logic rel;
    int   run;
    int   held;
    if (!rstN) begin
      mHist0     <= 1'b0;
      mHist1     <= 1'b0;
      mRun       <= 0;
      mHeld      <= 0;
      expLevel   <= 1'b0;
      expPulse   <= 1'b0;
      expRelease <= 1'b0;
    end else begin
      seen = mHist1;
      lvl  = expLevel;
      run  = mRun;
      held = mHeld;
      pul  = 1'b0;
      rel  = 1'b0;
      if (seen != lvl) begin
        run = run + 1;
        if (run == DEB + 1) begin
          lvl  = seen;
          run  = 0;
          held = 0;
          if (seen) pul = 1'b1;
          else      rel = 1'b1;
        end
      end else begin
        if (lvl) begin
          if (run > 0) begin
            held = 0;
          end else begin
            held = held + 1;
`ifdef AUTO_REPEAT_EN
            if (held == RDELAY || (held > RDELAY && (held - RDELAY) % RPERIOD == 0))
              pul = 1'b1;
`endif
          end
        end
        run = 0;
      end
      mHist1     <= mHist0;
      mHist0     <= btn;
      mRun       <= run;
      mHeld      <= held;
      expLevel   <= lvl;
      expPulse   <= pul;
      expRelease <= rel;
    end
  end

  // Compares the DUT against the model on every cycle, just after the edge.
  always @(posedge clk) begin
    #1;
    checkOutput("level", btnLevel, expLevel);
    checkOutput("pulse", btnPulse, expPulse);
    checkOutput("release", btnRelease, expRelease);
    checkOutput("exclusive", btnPulse & btnRelease, 1'b0);
  end

  // Event counters used by the directed sequences.
  always @(posedge clk) begin
    #1;
    if (btnPulse === 1'b1)   pulseCount   <= pulseCount + 1;
    if (btnRelease === 1'b1) releaseCount <= releaseCount + 1;
  end

  initial begin
    logic pat [7];
    int   snap;
    int   expRepeat;
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset held low while the pin toggles: every output stays low.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk) btn = ~btn;
      waitEdges(1);
      checkOutput("rst_level", btnLevel, 1'b0);
      checkOutput("rst_pulse", btnPulse, 1'b0);
      checkOutput("rst_release", btnRelease, 1'b0);
    end
    @(negedge clk);
    btn  = 1'b0;
    rstN = 1'b1;
    waitEdges(20);
    checkOutput("idle_level", btnLevel, 1'b0);
    checkCount("idle_pulses", pulseCount, 0);

    // Clean press: sampled high at edge 0, so level and pulse rise at edge 6.
    @(negedge clk) btn = 1'b1;
    @(posedge clk);
    waitEdges(5);
    checkOutput("press_e5_pulse", btnPulse, 1'b0);
    checkOutput("press_e5_level", btnLevel, 1'b0);
    waitEdges(1);
    checkOutput("press_e6_pulse", btnPulse, 1'b1);
    checkOutput("press_e6_level", btnLevel, 1'b1);
    waitEdges(1);
    checkOutput("press_e7_pulse", btnPulse, 1'b0);
    checkOutput("press_e7_level", btnLevel, 1'b1);

    // Release: sampled low at edge 0, so the release strobe comes at edge 6.
    @(negedge clk) btn = 1'b0;
    @(posedge clk);
    waitEdges(5);
    checkOutput("rel_e5_release", btnRelease, 1'b0);
    checkOutput("rel_e5_level", btnLevel, 1'b1);
    waitEdges(1);
    checkOutput("rel_e6_release", btnRelease, 1'b1);
    checkOutput("rel_e6_level", btnLevel, 1'b0);
    waitEdges(1);
    checkOutput("rel_e7_release", btnRelease, 1'b0);

    // A two-cycle low glitch while pressed must not produce a release.
    @(negedge clk);
    applyStimulus(1'b1, 12);
    snap = releaseCount;
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 15);
    checkOutput("glitch_level", btnLevel, 1'b1);
    checkCount("glitch_releases", releaseCount, snap);
    applyStimulus(1'b0, 12);
    checkOutput("glitch_after_rel", btnLevel, 1'b0);

    // Bounce 1,1,0,1,0,1,1 then held: the stable rise is sampled at edge 5,
    // so the only pulse comes at edge 11.
    snap = pulseCount;
    @(negedge clk) btn = pat[0];
    @(posedge clk);
    for (int i = 1; i < 7; i++) begin
      @(negedge clk) btn = pat[i];
      @(posedge clk);
    end
    waitEdges(4);
    checkOutput("bounce_e10_pulse", btnPulse, 1'b0);
    checkCount("bounce_no_early", pulseCount, snap);
    waitEdges(1);
    checkOutput("bounce_e11_pulse", btnPulse, 1'b1);
    waitEdges(1);
    checkCount("bounce_one_pulse", pulseCount, snap + 1);

    // Asynchronous reset while pressed: the level drops with no clock edge.
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("async_level", btnLevel, 1'b0);
    checkOutput("async_pulse", btnPulse, 1'b0);
    @(negedge clk) rstN = 1'b1;

    // Reset again mid-count (counter at 2 after edge 4), then restart with
    // the button still held: the pulse comes after the full debounce time.
    @(posedge clk);
    waitEdges(4);
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("midcnt_level", btnLevel, 1'b0);
    checkOutput("midcnt_pulse", btnPulse, 1'b0);
    @(negedge clk) rstN = 1'b1;
    @(posedge clk);
    waitEdges(5);
    checkOutput("restart_e5_pulse", btnPulse, 1'b0);
    waitEdges(1);
    checkOutput("restart_e6_pulse", btnPulse, 1'b1);
    checkOutput("restart_e6_level", btnLevel, 1'b1);

    // Long hold: count pulses from the press pulse (edge 6) through edge 45.
    // With auto-repeat the pulses fall at +0, +10, +15, +20, +25, +30, +35.
    snap = pulseCount;
    waitEdges(39);
`ifdef AUTO_REPEAT_EN
    expRepeat = 7;
`else
    expRepeat = 1;
`endif
    checkCount("hold_pulses", pulseCount - snap + 1, expRepeat);
    @(negedge clk);
    applyStimulus(1'b0, 10);

    // Random run: mostly short bounces, some long holds, and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        rstN = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        rstN = 1'b1;
      end
      if ($urandom_range(0, 3) == 0)
        applyStimulus(1'($urandom_range(0, 1)), $urandom_range(5, 30));
      else
        applyStimulus(1'($urandom_range(0, 1)), $urandom_range(1, 4));
    end
    applyStimulus(1'b0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
